// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: boot hold, load-use stall, branch flush and dmem-wait sequencing for a 5-stage pipe.
// Define HAZARD_PERF_EN to build the stall/flush/wait performance counters; otherwise they read 0.
module pipeline_hazard_ctrl #(
  parameter int BOOT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_flush,
  output logic             mem_wb_bubble,
  output logic [1:0]       state,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] wait_count
);
  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int TW = $clog2(MEM_TIMEOUT + 2);
  typedef enum logic [1:0] {BOOT = 2'b00, RUN = 2'b01, MEM_WAIT = 2'b10, ERROR = 2'b11} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] boot_q, boot_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic err_q, err_d;
  logic hazard, freeze;
  assign hazard = ex_mem_read && ex_rt != 5'd0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  assign freeze = mem_access && !dmem_ready;
  assign state = state_q;
  assign mem_timeout_err = err_q;
  always_comb begin
    state_d = state_q;
    boot_d = boot_q;
    tmo_d = tmo_q;
    err_d = err_q;
    {pc_write, if_id_write, id_ex_write, ex_mem_write} = '0;
    {if_id_flush, id_ex_bubble, ex_mem_flush, mem_wb_bubble} = '0;
    case (state_q)
      BOOT: begin
        {id_ex_write, ex_mem_write, if_id_flush} = '1;
        boot_d = boot_q + BW'(1);
        if (boot_q == BW'(BOOT_CYCLES - 1)) state_d = RUN;
      end
      RUN: begin
        if (freeze) begin
          mem_wb_bubble = 1'b1;
          state_d = MEM_WAIT;
          tmo_d = TW'(1);
        end else if (mem_branch_taken)
          {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_bubble, ex_mem_flush} = '1;
        else if (hazard)
          {id_ex_write, ex_mem_write, id_ex_bubble} = '1;
        else
          {pc_write, if_id_write, id_ex_write, ex_mem_write} = '1;
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          {pc_write, if_id_write, id_ex_write, ex_mem_write} = '1;
          state_d = RUN;
          tmo_d = '0;
        end else begin
          mem_wb_bubble = 1'b1;
          tmo_d = tmo_q + TW'(1);
          if (tmo_d >= TW'(MEM_TIMEOUT)) begin
            err_d = 1'b1;
            state_d = ERROR;
          end
        end
      end
      default: mem_wb_bubble = 1'b1;
    endcase
    if (!reset) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write} = '0;
      {if_id_flush, id_ex_bubble, ex_mem_flush, mem_wb_bubble} = '0;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= BOOT;
      boot_q <= '0;
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      boot_q <= boot_d;
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, wait_cnt_q, wait_cnt_d;
  // Only a stall bubbles ID/EX without a flush; every frozen cycle outside ERROR is a wait cycle.
  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(id_ex_bubble && !ex_mem_flush);
    flush_cnt_d = flush_cnt_q + CNT_W'(ex_mem_flush);
    wait_cnt_d = wait_cnt_q + CNT_W'(mem_wb_bubble && state_q != ERROR);
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
  assign wait_count = wait_cnt_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
  assign wait_count = '0;
`endif
endmodule
